// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer: packs multi-lane RVFI retires into a FIFO and replays them one per cycle in order.
module rvfi_retire_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NRET-1:0]          valid_i,
    input  logic [NRET*64-1:0]       order_i,
    input  logic [NRET*ILEN-1:0]     insn_i,
    input  logic [NRET-1:0]          trap_i,
    input  logic [NRET*XLEN-1:0]     pc_rdata_i,
    input  logic [NRET*5-1:0]        rd_addr_i,
    input  logic [NRET*XLEN-1:0]     rd_wdata_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [63:0]              out_order_o,
    output logic [ILEN-1:0]          out_insn_o,
    output logic                     out_trap_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [4:0]               out_rd_addr_o,
    output logic [XLEN-1:0]          out_rd_wdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     order_err_o,
    output logic                     lane_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0]     order;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } rec_t;

    rec_t            mem_q [DEPTH];
    rec_t            head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, n;
    logic [CW-1:0]   offs [NRET];
    logic            gap, hole, push, pop, in_ready;
    logic            overflow_q, order_err_q, lane_err_q, have_exp_q;
    logic [63:0]     exp_q;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        n    = '0;
        gap  = 1'b0;
        hole = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            offs[k] = n;
            n       = n + CW'(valid_i[k]);
            gap     = gap | (hole & valid_i[k]);
            hole    = hole | ~valid_i[k];
        end
        in_ready = count_q <= CW'(DEPTH - NRET);
        push     = |valid_i & in_ready;
        pop      = (count_q != '0) & out_ready_i;
        wr_ptr_d = push ? wr_ptr_q + AW'(n) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (push ? n : '0) - CW'(pop);
        head     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NRET; k++)
            if (push && valid_i[k])
                mem_q[wr_ptr_q + AW'(offs[k])] <= '{
                    order: order_i[k*64 +: 64],
                    insn:  insn_i[k*ILEN +: ILEN],
                    trap:  trap_i[k],
                    pc:    pc_rdata_i[k*XLEN +: XLEN],
                    rd:    rd_addr_i[k*5 +: 5],
                    wdata: rd_wdata_i[k*XLEN +: XLEN]
                };
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
            lane_err_q  <= 1'b0;
            have_exp_q  <= 1'b0;
            exp_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | (|valid_i & ~in_ready);
            lane_err_q <= lane_err_q | (push & gap);
            if (pop) begin
                order_err_q <= order_err_q | (have_exp_q && head.order != exp_q);
                exp_q       <= head.order + 64'd1;
                have_exp_q  <= 1'b1;
            end
        end
    end

    assign in_ready_o     = in_ready;
    assign out_valid_o    = count_q != '0;
    assign out_order_o    = head.order;
    assign out_insn_o     = head.insn;
    assign out_trap_o     = head.trap;
    assign out_pc_o       = head.pc;
    assign out_rd_addr_o  = head.rd;
    assign out_rd_wdata_o = head.wdata;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign order_err_o    = order_err_q;
    assign lane_err_o     = lane_err_q;
endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb_rvfi_retire_serializer: directed checks of packing, ordering, overflow and flags.
module tb_rvfi_retire_serializer;
    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   valid_i;
    logic [127:0] order_i;
    logic [63:0]  insn_i;
    logic [1:0]   trap_i;
    logic [127:0] pc_rdata_i;
    logic [9:0]   rd_addr_i;
    logic [127:0] rd_wdata_i;
    logic         in_ready_o, out_valid_o, out_ready_i;
    logic [63:0]  out_order_o;
    logic [31:0]  out_insn_o;
    logic         out_trap_o;
    logic [63:0]  out_pc_o;
    logic [4:0]   out_rd_addr_o;
    logic [63:0]  out_rd_wdata_o;
    logic [3:0]   count_o;
    logic         overflow_o, order_err_o, lane_err_o;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    rvfi_retire_serializer dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .order_i(order_i), .insn_i(insn_i),
        .trap_i(trap_i), .pc_rdata_i(pc_rdata_i), .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_order_o(out_order_o), .out_insn_o(out_insn_o), .out_trap_o(out_trap_o),
        .out_pc_o(out_pc_o), .out_rd_addr_o(out_rd_addr_o), .out_rd_wdata_o(out_rd_wdata_o),
        .count_o(count_o), .overflow_o(overflow_o), .order_err_o(order_err_o), .lane_err_o(lane_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i = '0;
    endtask

    task automatic lane(input int k, input logic [63:0] o);
        valid_i[k]             = 1'b1;
        order_i[k*64 +: 64]    = o;
        insn_i[k*32 +: 32]     = o[31:0] ^ 32'hdeadbeef;
        trap_i[k]              = o[0];
        pc_rdata_i[k*64 +: 64] = o << 2;
        rd_addr_i[k*5 +: 5]    = o[4:0];
        rd_wdata_i[k*64 +: 64] = ~o;
    endtask

    task automatic flags0(input string tag);
        chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
        chk({tag, "_oerr"}, 64'(order_err_o), 64'd0);
        chk({tag, "_lerr"}, 64'(lane_err_o), 64'd0);
    endtask

    initial begin
        int np, popped, cyc;
        rst = 1'b1; valid_i = '0; order_i = '0; insn_i = '0; trap_i = '0;
        pc_rdata_i = '0; rd_addr_i = '0; rd_wdata_i = '0; out_ready_i = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_order", out_order_o, 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        flags0("rst");

        // two-lane beat, immediate drain
        lane(0, 64'd5); lane(1, 64'd6); out_ready_i = 1'b1;
        step(); idle();
        chk("t1_valid", 64'(out_valid_o), 64'd1);
        chk("t1_head5", out_order_o, 64'd5);
        chk("t1_insn5", 64'(out_insn_o), 64'(32'd5 ^ 32'hdeadbeef));
        chk("t1_count2", 64'(count_o), 64'd2);
        step();
        chk("t1_head6", out_order_o, 64'd6);
        chk("t1_wdata6", out_rd_wdata_o, ~64'd6);
        step();
        chk("t1_empty", 64'(out_valid_o), 64'd0);
        flags0("t1");

        // fill to full, then overflow
        out_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            lane(0, 64'(7 + 2*b)); lane(1, 64'(8 + 2*b));
            step();
            chk("t2_count", 64'(count_o), 64'(2*(b+1)));
            chk("t2_in_ready", 64'(in_ready_o), 64'(b < 3));
        end
        lane(0, 64'd15); lane(1, 64'd16);
        step();
        chk("t2_ovf", 64'(overflow_o), 64'd1);
        chk("t2_count8", 64'(count_o), 64'd8);
        chk("t2_head7", out_order_o, 64'd7);

        // push blocked by pre-pop count while popping
        out_ready_i = 1'b1;
        step(); idle(); out_ready_i = 1'b0;
        chk("t3_count7", 64'(count_o), 64'd7);
        chk("t3_head8", out_order_o, 64'd8);
        chk("t3_in_ready", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        for (int i = 8; i <= 14; i++) begin
            chk("t3_drain", out_order_o, 64'(i));
            step();
        end
        out_ready_i = 1'b0;
        chk("t3_empty", 64'(out_valid_o), 64'd0);
        chk("t3_oerr", 64'(order_err_o), 64'd0);

        // order gap 10,11,13
        rst = 1'b1; step(); rst = 1'b0;
        chk("t4_ovf_clr", 64'(overflow_o), 64'd0);
        lane(0, 64'd10); lane(1, 64'd11); step();
        idle(); lane(0, 64'd13); step(); idle();
        chk("t4_count3", 64'(count_o), 64'd3);
        out_ready_i = 1'b1;
        step();
        chk("t4_head11", out_order_o, 64'd11);
        chk("t4_oerr_a", 64'(order_err_o), 64'd0);
        step();
        chk("t4_head13", out_order_o, 64'd13);
        chk("t4_oerr_b", 64'(order_err_o), 64'd0);
        step();
        chk("t4_oerr_c", 64'(order_err_o), 64'd1);
        out_ready_i = 1'b0;
        step();
        chk("t4_oerr_sticky", 64'(order_err_o), 64'd1);
        chk("t4_lerr0", 64'(lane_err_o), 64'd0);

        // hole in lanes: valid=10
        lane(1, 64'd20); step(); idle();
        chk("t5_count1", 64'(count_o), 64'd1);
        chk("t5_head20", out_order_o, 64'd20);
        chk("t5_pc", out_pc_o, 64'd80);
        chk("t5_rd", 64'(out_rd_addr_o), 64'd20);
        chk("t5_trap", 64'(out_trap_o), 64'd0);
        chk("t5_lerr", 64'(lane_err_o), 64'd1);

        // rotation across the wrap with random backpressure, then reset
        rst = 1'b1; step(); rst = 1'b0;
        flags0("t6_pre");
        np = 100; popped = 0; cyc = 0;
        while ((np < 120 || popped < 15) && cyc < 400) begin
            idle();
            if (np < 120 && in_ready_o) begin
                lane(0, 64'(np)); lane(1, 64'(np + 1)); np += 2;
            end
            out_ready_i = (popped < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (out_valid_o && out_ready_i) begin
                chk("t6_order", out_order_o, 64'(100 + popped));
                popped++;
            end
            step(); cyc++;
        end
        idle(); out_ready_i = 1'b0;
        chk("t6_done", 64'(cyc < 400), 64'd1);
        chk("t6_count5", 64'(count_o), 64'd5);
        chk("t6_head115", out_order_o, 64'd115);
        flags0("t6_run");
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_rst_count", 64'(count_o), 64'd0);
        chk("t6_rst_valid", 64'(out_valid_o), 64'd0);
        chk("t6_rst_order", out_order_o, 64'd0);
        flags0("t6_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
